// File: rtl/spi_ram_port.sv
// spi_ram_port: SPI slave giving serial read/write access to an internal word RAM.
// A transaction is an 8-bit command (0x03 READ, 0x02 WRITE), an ADDR_W-bit address
// and then data words, all MSB first. sck is the only clock.
// Optional feature macro: SPI_RAM_PORT_BURST_EN. When defined, a transaction keeps
// transferring words with auto-incrementing address. When undefined, only one word
// is transferred and the rest of the transaction is ignored.
module spi_ram_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic sck,
  input  logic rst_n,
  input  logic ss,
  input  logic mosi,
  output logic miso,
  output logic busy,
  output logic cmd_err
);

  localparam int MAX_BITS = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CNT_W    = $clog2(MAX_BITS);
  localparam int BIT_W    = $clog2(DATA_W);
  localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [7:0]        CMD_READ  = 8'h03;
  localparam logic [7:0]        CMD_WRITE = 8'h02;
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    CMD    = 2'd0,
    ADDR   = 2'd1,
    DATA   = 2'd2,
    IGNORE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_rd_q, is_rd_d;
  logic                miso_q, miso_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   shift_in;
  logic [DATA_W-1:0]   rd_word;
  logic [BIT_W-1:0]    bit_sel;
  logic [MEM_AW-1:0]   mem_idx;
  logic [ADDR_W-1:0]   addr_inc;
  logic                addr_ok;
  logic                wr_en;

  // Datapath helpers: incoming shift word, range check, read word and next address.
  always_comb begin
    shift_in = {shift_q[DATA_W-2:0], mosi};
    mem_idx  = addr_q[MEM_AW-1:0];
    addr_ok  = ({1'b0, addr_q} < DEPTH_X);
    rd_word  = addr_ok ? mem_q[mem_idx] : '0;
    bit_sel  = BIT_W'(DATA_LAST - cnt_q);
    addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
  end

  // Next-state and output logic for the command/address/data sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    is_rd_d = is_rd_q;
    miso_d  = 1'b0;
    err_d   = err_q;
    wr_en   = 1'b0;

    if (ss) begin
      // Deselected: park in CMD with cleared counters; the error flag is kept
      // so the host can read it after the transaction ends.
      state_d = CMD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        CMD: begin
          if (cnt_q == '0) begin
            err_d = 1'b0;
          end
          shift_d = shift_in;
          if (cnt_q == CMD_LAST) begin
            cnt_d = '0;
            if (shift_in[7:0] == CMD_READ) begin
              state_d = ADDR;
              is_rd_d = 1'b1;
            end else if (shift_in[7:0] == CMD_WRITE) begin
              state_d = ADDR;
              is_rd_d = 1'b0;
            end else begin
              state_d = IGNORE;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ADDR: begin
          addr_d = {addr_q[ADDR_W-2:0], mosi};
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DATA: begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end
          if (is_rd_q) begin
            miso_d = rd_word[bit_sel];
          end else begin
            shift_d = shift_in;
          end
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            // Write commits only when the full word has arrived in range.
            wr_en = !is_rd_q && addr_ok;
`ifdef SPI_RAM_PORT_BURST_EN
            addr_d = addr_inc;
`else
            state_d = IGNORE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          // IGNORE: discard mosi until deselect.
          state_d = IGNORE;
        end
      endcase
    end

    busy_d = (state_d == ADDR) || (state_d == DATA);
  end

  // Sequencer and output registers with asynchronous active-low reset.
  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CMD;
      cnt_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      is_rd_q <= 1'b0;
      miso_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      is_rd_q <= is_rd_d;
      miso_q  <= miso_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Memory write port; contents deliberately survive reset.
  always_ff @(posedge sck) begin
    if (wr_en) begin
      mem_q[mem_idx] <= shift_in;
    end
  end

  assign miso    = miso_q;
  assign busy    = busy_q;
  assign cmd_err = err_q;

endmodule

// File: doc/spi_ram_port.md
SPI_RAM_PORT -- requirements
Module: spi_ram_port

Interface
REQ-001 Parameter DATA_W, default 32, memory word width in bits, legal range 8..64.
REQ-002 Parameter ADDR_W, default 8, width of the address field shifted in on mosi.
REQ-003 Parameter DEPTH, default 256, number of words in the internal memory array, with DEPTH <= 2**ADDR_W.
REQ-004 Port sck, input, 1 bit, the only clock; all state updates occur on its rising edge.
REQ-005 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 Port ss, input, 1 bit, active-low slave select; low means a transaction is in progress.
REQ-007 Port mosi, input, 1 bit, serial data in, MSB first.
REQ-008 Port miso, output, 1 bit, registered serial data out, MSB first.
REQ-009 Port busy, output, 1 bit, registered; high while the state is ADDR or DATA.
REQ-010 Port cmd_err, output, 1 bit, registered; sticky error flag for the current transaction.

Function
REQ-011 FSM states SHALL be CMD, ADDR, DATA and IGNORE; the state SHALL be CMD after reset and on every edge sampled with ss high.
REQ-012 On every edge sampled with ss high, bit counters SHALL clear and miso SHALL be driven 0; cmd_err SHALL hold its value.
REQ-013 CMD SHALL shift in 8 bits; on the 8th bit, 0x03 (READ) or 0x02 (WRITE) SHALL go to ADDR, and any other value SHALL go to IGNORE and set cmd_err.
REQ-014 The first CMD bit of a transaction SHALL clear cmd_err.
REQ-015 ADDR SHALL shift in ADDR_W bits into the address register; after the last bit the FSM SHALL go to DATA.
REQ-016 READ: on the N edges following the last address bit, miso SHALL present mem[addr] from bit DATA_W-1 down to bit 0, one bit per edge.
REQ-017 WRITE: DATA SHALL shift in DATA_W bits; the edge that samples bit 0 SHALL write the assembled word to mem[addr] on that same edge.
REQ-018 At each word boundary, addr SHALL increment, wrapping DEPTH-1 -> 0, and the next word SHALL start on the following edge with no gap.
REQ-019 If addr >= DEPTH, reads SHALL return all zeros, writes SHALL be dropped, and cmd_err SHALL be set.
REQ-020 In IGNORE, mosi SHALL be ignored, miso SHALL be 0, and the FSM SHALL stay in IGNORE until ss is high.
REQ-021 If ss rises mid-word, a partial write SHALL be discarded and the memory SHALL be left unchanged.
REQ-022 miso SHALL be 0 in CMD and ADDR.

Reset
REQ-023 rst_n low SHALL immediately force: state CMD, counters 0, addr 0, miso 0, busy 0, cmd_err 0.
REQ-024 Memory contents SHALL NOT be cleared by reset.
REQ-025 Reset asserted mid-transaction SHALL abort that transaction; no partial write SHALL occur.
REQ-026 The first edge after rst_n deasserts with ss low SHALL be treated as CMD bit 7.

Configuration
REQ-027 The macro SPI_RAM_PORT_BURST_EN SHALL control burst transfers.
REQ-028 With SPI_RAM_PORT_BURST_EN defined, behaviour SHALL follow REQ-018: unlimited words per transaction with auto-increment.
REQ-029 Without SPI_RAM_PORT_BURST_EN, after one word the FSM SHALL enter IGNORE; further reads SHALL output 0, further writes SHALL be dropped, and cmd_err SHALL be unaffected.

Verification
REQ-030 Scenario: defaults; WRITE 0x02, addr 0x10, data 0xDEADBEEF, ss high; then READ 0x03, addr 0x10 -> miso returns 0xDEADBEEF MSB first, cmd_err 0.
REQ-031 Scenario: burst (BURST_EN) WRITE at addr 0xFF of words 0x11111111 and 0x22222222 -> mem[0xFF]=0x11111111, mem[0x00]=0x22222222; reading back 2 words from 0xFF matches.
REQ-032 Scenario: command 0xA5 followed by 40 sck edges -> miso constantly 0, busy 0, cmd_err 1; the next transaction's first CMD bit clears cmd_err.
REQ-033 Scenario: WRITE addr 0x20 of 0x12345678, ss rises after 20 data bits -> mem[0x20] keeps its prior value.
REQ-034 Scenario: DEPTH=200, READ addr 0xC8 -> miso 32 zero bits, cmd_err 1.
REQ-035 Scenario: rst_n pulsed low mid-READ with no sck edge -> miso, busy and cmd_err go 0 immediately; after release, a fresh READ returns correct data.
